cdma_frame_sync: RTL and testbench

- Downstream of the CDMA despreader/correlator. Consumes one recovered bit per data-valid strobe.
- Hunts for an 8-bit sync word, then parses a length byte and the payload bytes.
- Delivers payload bytes through a small FIFO on a valid/ready byte interface, with frame_start/frame_end sideband.
- Gives the RISC-V side a byte-oriented, framed receive stream instead of raw bits.

---
 rtl/cdma_pkg.sv | 21 ++
 rtl/cdma_byte_fifo.sv | 62 ++++++
 rtl/cdma_frame_sync.sv | 208 ++++++++++++++++++++
 tb/tb_cdma_frame_sync.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdma_pkg.sv
// Shared types and constants for the CDMA frame synchroniser.
// State encoding, default sync word, byte width and FIFO entry layout.
package cdma_pkg;

    typedef enum logic [1:0] {
        HUNT,
        LEN,
        PAYLOAD,
        CHECK
    } state_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hD3;
    localparam int         BYTE_W       = 8;

    typedef struct packed {
        logic              first;
        logic              last;
        logic [BYTE_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/cdma_byte_fifo.sv
// Synchronous first-word fall-through FIFO of framed payload bytes.
// Ports: clk, rst (async, active-high), push/wr_data, pop, head, full, empty.
module cdma_byte_fifo
    import cdma_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  fifo_entry_t wr_data,
    input  logic        pop,
    output fifo_entry_t head,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fifo_entry_t    mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           do_push;
    logic           do_pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // A pop in the same cycle frees the slot, so push is allowed while full.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage is written on the clock, so the head is a registered value.
    assign head = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cdma_frame_sync.sv
// Bit-serial frame synchroniser: sync hunt, length parse, payload bytes to FIFO.
// Ports: clk, rst, bit_in/bit_valid in; byte_out/byte_valid/byte_ready,
// frame_start/frame_end, locked, len_err, ovf_err out.
// Macro CDMA_FRAME_CHECKSUM_EN adds a trailing check byte and csum_err output.
module cdma_frame_sync
    import cdma_pkg::*;
#(
    parameter logic [7:0] SYNC_PATTERN = SYNC_DEFAULT,
    parameter int         MAX_LEN      = 16,
    parameter int         FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       frame_start,
    output logic       frame_end,
    output logic       locked,
    output logic       len_err,
    output logic       ovf_err
`ifdef CDMA_FRAME_CHECKSUM_EN
   ,output logic       csum_err
`endif
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t      state;
    // Last 7 received bits; with bit_in they form the 8-bit shifted word.
    logic [6:0]  sreg;
    logic [2:0]  fill;
    logic [2:0]  bit_cnt;
    logic [7:0]  byte_cnt;
    logic [7:0]  len;
    logic [7:0]  rx_byte;
    logic        byte_done;
    logic        is_last;
    logic        push;
    logic        pop;
    logic        drop;
    logic        fifo_full;
    logic        fifo_empty;
    fifo_entry_t wr_entry;
    fifo_entry_t head;
`ifdef CDMA_FRAME_CHECKSUM_EN
    logic [7:0]  csum;
    fifo_entry_t stage;
`endif

    assign rx_byte   = {sreg, bit_in};
    assign byte_done = bit_valid && (bit_cnt == 3'd7);
    assign is_last   = (byte_cnt == len - 8'd1);

    always_comb begin
        push     = 1'b0;
        wr_entry = '0;
        if (byte_done && state == PAYLOAD) begin
            wr_entry.first = (byte_cnt == 8'd0);
            wr_entry.last  = is_last;
            wr_entry.data  = rx_byte;
`ifdef CDMA_FRAME_CHECKSUM_EN
            // The last byte waits in the stage until the check byte lands.
            push = !is_last;
`else
            push = 1'b1;
`endif
        end
`ifdef CDMA_FRAME_CHECKSUM_EN
        if (byte_done && state == CHECK) begin
            push     = 1'b1;
            wr_entry = stage;
        end
`endif
    end

    assign pop  = byte_valid && byte_ready;
    assign drop = push && fifo_full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= HUNT;
            sreg     <= '0;
            fill     <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            len      <= '0;
            locked   <= 1'b0;
            len_err  <= 1'b0;
            ovf_err  <= 1'b0;
`ifdef CDMA_FRAME_CHECKSUM_EN
            csum     <= '0;
            stage    <= '0;
            csum_err <= 1'b0;
`endif
        end else begin
            len_err <= 1'b0;
            ovf_err <= 1'b0;
`ifdef CDMA_FRAME_CHECKSUM_EN
            csum_err <= 1'b0;
`endif
            if (bit_valid) begin
                sreg    <= rx_byte[6:0];
                bit_cnt <= bit_cnt + 3'd1;
                unique case (state)
                    HUNT: begin
                        bit_cnt <= '0;
                        if (fill != 3'd7) begin
                            fill <= fill + 3'd1;
                        end
                        // Compare only once 7 history bits are genuine.
                        if (fill == 3'd7 && rx_byte == SYNC_PATTERN) begin
                            state  <= LEN;
                            locked <= 1'b1;
                        end
                    end
                    LEN: begin
                        if (bit_cnt == 3'd7) begin
                            if (rx_byte == 8'd0 || rx_byte > MAX_LEN_B) begin
                                len_err <= 1'b1;
                                state   <= HUNT;
                                sreg    <= '0;
                                fill    <= '0;
                                locked  <= 1'b0;
                            end else begin
                                len      <= rx_byte;
                                byte_cnt <= '0;
                                state    <= PAYLOAD;
`ifdef CDMA_FRAME_CHECKSUM_EN
                                csum     <= rx_byte;
`endif
                            end
                        end
                    end
                    PAYLOAD: begin
                        if (bit_cnt == 3'd7) begin
                            byte_cnt <= byte_cnt + 8'd1;
`ifdef CDMA_FRAME_CHECKSUM_EN
                            csum <= csum + rx_byte;
`endif
                            if (drop) begin
                                ovf_err <= 1'b1;
                                state   <= HUNT;
                                sreg    <= '0;
                                fill    <= '0;
                                locked  <= 1'b0;
                            end else if (is_last) begin
`ifdef CDMA_FRAME_CHECKSUM_EN
                                stage.first <= (byte_cnt == 8'd0);
                                stage.last  <= 1'b1;
                                stage.data  <= rx_byte;
                                state       <= CHECK;
`else
                                state  <= HUNT;
                                sreg   <= '0;
                                fill   <= '0;
                                locked <= 1'b0;
`endif
                            end
                        end
                    end
`ifdef CDMA_FRAME_CHECKSUM_EN
                    CHECK: begin
                        if (bit_cnt == 3'd7) begin
                            if (drop) begin
                                ovf_err <= 1'b1;
                            end else begin
                                csum_err <= (rx_byte != csum);
                            end
                            state  <= HUNT;
                            sreg   <= '0;
                            fill   <= '0;
                            locked <= 1'b0;
                        end
                    end
`endif
                    default: begin
                        state  <= HUNT;
                        sreg   <= '0;
                        fill   <= '0;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    cdma_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (wr_entry),
        .pop     (pop),
        .head    (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign byte_valid  = !fifo_empty;
    assign byte_out    = head.data;
    assign frame_start = byte_valid && head.first;
    assign frame_end   = byte_valid && head.last;

endmodule

// File: tb/tb_cdma_frame_sync.sv
// Directed-vector bench for cdma_frame_sync.
// Each task drives one scenario and compares against hand-computed values.
module tb_cdma_frame_sync;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_in;
    logic       bit_valid;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready;
    logic       frame_start;
    logic       frame_end;
    logic       locked;
    logic       len_err;
    logic       ovf_err;
`ifdef CDMA_FRAME_CHECKSUM_EN
    logic       csum_err;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cdma_frame_sync #(
        .SYNC_PATTERN (8'hD3),
        .MAX_LEN      (16),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .byte_out    (byte_out),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .locked      (locked),
        .len_err     (len_err),
        .ovf_err     (ovf_err)
`ifdef CDMA_FRAME_CHECKSUM_EN
       ,.csum_err    (csum_err)
`endif
    );

    task automatic send_bit(input logic b);
        @(negedge clk);
        bit_in    = b;
        bit_valid = 1'b1;
        @(posedge clk);
        #1 bit_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic pop_one();
        @(negedge clk);
        byte_ready = 1'b1;
        @(posedge clk);
        #1 byte_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bit_in = 1'b0;
        bit_valid = 1'b0;
        byte_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({byte_out, byte_valid, frame_start, frame_end, locked, len_err, ovf_err} !== 14'd0) begin
            miscompares++;
            $display("FAIL reset outs=%h want 0",
                {byte_out, byte_valid, frame_start, frame_end, locked, len_err, ovf_err});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] c3 = 8'hC3;
        send_byte(8'hD3);
        vectors++;
        if (locked !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_lock got=%b want 1", locked);
        end
        send_byte(8'h02);
        send_byte(8'h5A);
        vectors++;
        if (byte_valid !== 1'b1 || byte_out !== 8'h5A || frame_start !== 1'b1 || frame_end !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_b0 v=%b d=%h s=%b e=%b want 1 5a 1 0", byte_valid, byte_out, frame_start, frame_end);
        end
        for (int i = 7; i >= 1; i--) send_bit(c3[i]);
        vectors++;
        if (locked !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_lock31 got=%b want 1", locked);
        end
        send_bit(c3[0]);
        vectors++;
        if (locked !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_unlock32 got=%b want 0", locked);
        end
        pop_one();
        vectors++;
        if (byte_valid !== 1'b1 || byte_out !== 8'hC3 || frame_start !== 1'b0 || frame_end !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_b1 v=%b d=%h s=%b e=%b want 1 c3 0 1", byte_valid, byte_out, frame_start, frame_end);
        end
        pop_one();
        vectors++;
        if (byte_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_empty got=%b want 0", byte_valid);
        end
    endtask

    task automatic test_noise();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        vectors++;
        if (locked !== 1'b0) begin
            miscompares++;
            $display("FAIL noise_nolock got=%b want 0", locked);
        end
        send_byte(8'hD3);
        send_byte(8'h01);
        send_byte(8'h7E);
        vectors++;
        if (byte_valid !== 1'b1 || byte_out !== 8'h7E || frame_start !== 1'b1 || frame_end !== 1'b1) begin
            miscompares++;
            $display("FAIL noise_b0 v=%b d=%h s=%b e=%b want 1 7e 1 1", byte_valid, byte_out, frame_start, frame_end);
        end
        pop_one();
        vectors++;
        if (byte_valid !== 1'b0 || locked !== 1'b0) begin
            miscompares++;
            $display("FAIL noise_one v=%b l=%b want 0 0", byte_valid, locked);
        end
    endtask

    task automatic test_len_err();
        logic [7:0] bad [2] = '{8'h00, 8'h11};
        for (int k = 0; k < 2; k++) begin
            send_byte(8'hD3);
            send_byte(bad[k]);
            vectors++;
            if (len_err !== 1'b1 || locked !== 1'b0) begin
                miscompares++;
                $display("FAIL lenerr_pulse%0d e=%b l=%b want 1 0", k, len_err, locked);
            end
            @(posedge clk);
            #1;
            vectors++;
            if (len_err !== 1'b0 || byte_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL lenerr_after%0d e=%b v=%b want 0 0", k, len_err, byte_valid);
            end
        end
        send_byte(8'hD3);
        send_byte(8'h01);
        send_byte(8'h5C);
        vectors++;
        if (byte_valid !== 1'b1 || byte_out !== 8'h5C || frame_start !== 1'b1 || frame_end !== 1'b1) begin
            miscompares++;
            $display("FAIL lenerr_next v=%b d=%h s=%b e=%b want 1 5c 1 1", byte_valid, byte_out, frame_start, frame_end);
        end
        pop_one();
    endtask

    task automatic test_overflow();
        logic [7:0] pay [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_byte(8'hD3);
        send_byte(8'h06);
        for (int k = 0; k < 4; k++) send_byte(pay[k]);
        vectors++;
        if (ovf_err !== 1'b0 || locked !== 1'b1 || byte_out !== 8'h11) begin
            miscompares++;
            $display("FAIL ovf_pre o=%b l=%b d=%h want 0 1 11", ovf_err, locked, byte_out);
        end
        send_byte(8'h55);
        vectors++;
        if (ovf_err !== 1'b1 || locked !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_pulse o=%b l=%b want 1 0", ovf_err, locked);
        end
        send_byte(8'h66);
        vectors++;
        if (ovf_err !== 1'b0 || locked !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_after o=%b l=%b want 0 0", ovf_err, locked);
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (byte_valid !== 1'b1 || byte_out !== pay[k] ||
                frame_start !== (k == 0) || frame_end !== 1'b0) begin
                miscompares++;
                $display("FAIL ovf_drain%0d v=%b d=%h s=%b e=%b want 1 %h %b 0",
                    k, byte_valid, byte_out, frame_start, frame_end, pay[k], k == 0);
            end
            pop_one();
        end
        vectors++;
        if (byte_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_empty got=%b want 0", byte_valid);
        end
        send_byte(8'hD3);
        send_byte(8'h01);
        send_byte(8'h3C);
        vectors++;
        if (byte_valid !== 1'b1 || byte_out !== 8'h3C || frame_start !== 1'b1 || frame_end !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_next v=%b d=%h s=%b e=%b want 1 3c 1 1", byte_valid, byte_out, frame_start, frame_end);
        end
        pop_one();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d [3] = '{8'hA1, 8'hB2, 8'hB3};
        logic [1:0] exp_se [3] = '{2'b11, 2'b10, 2'b01};
        send_byte(8'hD3);
        send_byte(8'h01);
        send_byte(8'hA1);
        send_byte(8'hD3);
        send_byte(8'h02);
        send_byte(8'hB2);
        send_byte(8'hB3);
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (byte_valid !== 1'b1 || byte_out !== exp_d[k] || {frame_start, frame_end} !== exp_se[k]) begin
                miscompares++;
                $display("FAIL b2b_%0d v=%b d=%h se=%b want 1 %h %b",
                    k, byte_valid, byte_out, {frame_start, frame_end}, exp_d[k], exp_se[k]);
            end
            pop_one();
        end
    endtask

    task automatic test_reset_mid();
        send_byte(8'hD3);
        send_byte(8'h03);
        send_byte(8'hAB);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        vectors++;
        if (byte_valid !== 1'b1 || byte_out !== 8'hAB || locked !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_pre v=%b d=%h l=%b want 1 ab 1", byte_valid, byte_out, locked);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if ({byte_out, byte_valid, frame_start, frame_end, locked, len_err, ovf_err} !== 14'd0) begin
            miscompares++;
            $display("FAIL rstmid_outs got=%h want 0",
                {byte_out, byte_valid, frame_start, frame_end, locked, len_err, ovf_err});
        end
        @(negedge clk);
        rst = 1'b0;
        send_byte(8'hD3);
        send_byte(8'h01);
        send_byte(8'h96);
        vectors++;
        if (byte_valid !== 1'b1 || byte_out !== 8'h96 || frame_start !== 1'b1 || frame_end !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_next v=%b d=%h s=%b e=%b want 1 96 1 1", byte_valid, byte_out, frame_start, frame_end);
        end
        pop_one();
    endtask

`ifdef CDMA_FRAME_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] chk [2] = '{8'h1F, 8'h20};
        for (int k = 0; k < 2; k++) begin
            send_byte(8'hD3);
            send_byte(8'h02);
            send_byte(8'h5A);
            send_byte(8'hC3);
            vectors++;
            if (byte_out !== 8'h5A || frame_start !== 1'b1 || frame_end !== 1'b0) begin
                miscompares++;
                $display("FAIL csum_b0_%0d d=%h s=%b e=%b want 5a 1 0", k, byte_out, frame_start, frame_end);
            end
            send_byte(chk[k]);
            vectors++;
            if (csum_err !== (k == 1)) begin
                miscompares++;
                $display("FAIL csum_err%0d got=%b want %b", k, csum_err, k == 1);
            end
            pop_one();
            vectors++;
            if (byte_valid !== 1'b1 || byte_out !== 8'hC3 || frame_end !== 1'b1) begin
                miscompares++;
                $display("FAIL csum_b1_%0d v=%b d=%h e=%b want 1 c3 1", k, byte_valid, byte_out, frame_end);
            end
            pop_one();
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef CDMA_FRAME_CHECKSUM_EN
        test_checksum();
`else
        test_basic();
        test_noise();
        test_len_err();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
